// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA pipeline widths, grid index type and hover FSM states
package vga_pkg;
    localparam int HCOUNT_W   = 11;
    localparam int RGB_W      = 12;
    localparam int GRID_IDX_W = 4;
    localparam int BLINK_BIT  = 4;

    typedef logic [GRID_IDX_W-1:0] grid_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } hover_state_t;
endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing plus pixel colour bundle passed between overlay layers
interface vga_if;
    import vga_pkg::*;

    logic [HCOUNT_W-1:0] hcount;
    logic [HCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_W-1:0]    rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/grid_cell_locator.sv
// rtl/grid_cell_locator.sv - maps the cursor to grid cell indices once per frame during vblank
module grid_cell_locator
    import vga_pkg::*;
#(
    parameter int X_POS      = 0,
    parameter int Y_POS      = 0,
    parameter int GRID_CELLS = 10,
    parameter int CELL_PITCH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vblnk,
    input  logic [HCOUNT_W-1:0] cursor_x,
    input  logic [HCOUNT_W-1:0] cursor_y,
    output grid_idx_t           hover_col,
    output grid_idx_t           hover_row,
    output logic                hover_valid
);
    localparam logic signed [11:0] PITCH_S  = 12'(CELL_PITCH);
    localparam logic signed [11:0] SPAN_S   = 12'(GRID_CELLS * CELL_PITCH);
    localparam grid_idx_t          ITER_MAX = GRID_IDX_W'(GRID_CELLS);

    hover_state_t       r_state;
    hover_state_t       w_next;
    logic               r_vblnk_d;
    logic signed [11:0] r_dx;
    logic signed [11:0] r_dy;
    grid_idx_t          r_qx;
    grid_idx_t          r_qy;
    grid_idx_t          r_iter;
    logic               r_outside;
    grid_idx_t          r_hover_col;
    grid_idx_t          r_hover_row;
    logic               r_hover_valid;

    logic               w_rise;
    logic signed [11:0] w_dx0;
    logic signed [11:0] w_dy0;
    logic               w_outside;
    logic               w_x_done;
    logic               w_y_done;

    assign w_rise    = vblnk & ~r_vblnk_d;
    assign w_dx0     = {1'b0, cursor_x} - 12'(X_POS);
    assign w_dy0     = {1'b0, cursor_y} - 12'(Y_POS);
    // The closing line sits at offset GSPAN-LINE_W and already belongs outside.
    assign w_outside = w_dx0[11] | (w_dx0 >= SPAN_S) | w_dy0[11] | (w_dy0 >= SPAN_S);
    assign w_x_done  = (r_dx < PITCH_S);
    assign w_y_done  = (r_dy < PITCH_S);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_next = CALC;
            CALC:    if ((w_x_done && w_y_done) || (r_iter == ITER_MAX)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Held high so a reset inside vblank does not look like a fresh frame edge.
            r_vblnk_d     <= 1'b1;
            r_dx          <= '0;
            r_dy          <= '0;
            r_qx          <= '0;
            r_qy          <= '0;
            r_iter        <= '0;
            r_outside     <= 1'b0;
            r_hover_col   <= '0;
            r_hover_row   <= '0;
            r_hover_valid <= 1'b0;
        end else begin
            r_vblnk_d <= vblnk;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_dx      <= w_dx0;
                        r_dy      <= w_dy0;
                        r_outside <= w_outside;
                        r_qx      <= '0;
                        r_qy      <= '0;
                        r_iter    <= '0;
                    end
                end
                CALC: begin
                    if (!w_x_done) begin
                        r_dx <= r_dx - PITCH_S;
                        r_qx <= r_qx + 1'b1;
                    end
                    if (!w_y_done) begin
                        r_dy <= r_dy - PITCH_S;
                        r_qy <= r_qy + 1'b1;
                    end
                    r_iter <= r_iter + 1'b1;
                end
                DONE: begin
                    r_hover_valid <= ~r_outside;
                    r_hover_col   <= r_outside ? '0 : r_qx;
                    r_hover_row   <= r_outside ? '0 : r_qy;
                end
                default: ;
            endcase
        end
    end

    assign hover_col   = r_hover_col;
    assign hover_row   = r_hover_row;
    assign hover_valid = r_hover_valid;
endmodule

// File: rtl/draw_grid_ctl.sv
// rtl/draw_grid_ctl.sv - N x N grid overlay with hover-cell fill; HOVER_BLINK_EN makes the fill blink
module draw_grid_ctl
    import vga_pkg::*;
#(
    parameter int               X_POS      = 0,
    parameter int               Y_POS      = 0,
    parameter int               GRID_CELLS = 10,
    parameter int               CELL_PITCH = 32,
    parameter int               LINE_W     = 2,
    parameter logic [RGB_W-1:0] LINE_RGB   = 12'hfff,
    parameter logic [RGB_W-1:0] HOVER_RGB  = 12'h0a0
) (
    input  logic                clk,
    input  logic                rst,
    vga_if.in                   in,
    vga_if.out                  out,
    input  logic [HCOUNT_W-1:0] cursor_x,
    input  logic [HCOUNT_W-1:0] cursor_y,
    output grid_idx_t           hover_col,
    output grid_idx_t           hover_row,
    output logic                hover_valid
);
    localparam int GSPAN = GRID_CELLS * CELL_PITCH + LINE_W;
    localparam int OFF_W = $clog2(CELL_PITCH);

    localparam logic [OFF_W-1:0]    OFF_LAST  = OFF_W'(CELL_PITCH - 1);
    localparam logic [OFF_W-1:0]    LINE_LAST = OFF_W'(LINE_W - 1);
    localparam logic [OFF_W-1:0]    LINE_W_C  = OFF_W'(LINE_W);
    localparam grid_idx_t           CELLS_C   = GRID_IDX_W'(GRID_CELLS);
    localparam logic [HCOUNT_W-1:0] X_START   = HCOUNT_W'(X_POS);
    localparam logic [HCOUNT_W-1:0] Y_START   = HCOUNT_W'(Y_POS);
    localparam logic [11:0]         X_LO      = 12'(X_POS);
    localparam logic [11:0]         X_HI      = 12'(X_POS + GSPAN);
    localparam logic [11:0]         Y_LO      = 12'(Y_POS);
    localparam logic [11:0]         Y_HI      = 12'(Y_POS + GSPAN);

    logic [OFF_W-1:0]    r_h_off;
    logic [OFF_W-1:0]    r_v_off;
    grid_idx_t           r_col;
    grid_idx_t           r_row;
    logic                r_in_grid;
    logic [HCOUNT_W-1:0] r_hc1;
    logic [HCOUNT_W-1:0] r_vc1;
    logic                r_hs1;
    logic                r_vs1;
    logic                r_hb1;
    logic                r_vb1;
    logic [RGB_W-1:0]    r_rgb1;

    logic                w_in_grid;
    logic                w_h_frozen;
    logic                w_v_frozen;
    logic                w_is_line;
    logic                w_blink_on;
    logic                w_hover_hit;
    logic [RGB_W-1:0]    w_rgb;

    grid_cell_locator #(
        .X_POS      (X_POS),
        .Y_POS      (Y_POS),
        .GRID_CELLS (GRID_CELLS),
        .CELL_PITCH (CELL_PITCH)
    ) u_locator (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (in.vblnk),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .hover_col   (hover_col),
        .hover_row   (hover_row),
        .hover_valid (hover_valid)
    );

    assign w_in_grid  = ({1'b0, in.hcount} >= X_LO) && ({1'b0, in.hcount} < X_HI) &&
                        ({1'b0, in.vcount} >= Y_LO) && ({1'b0, in.vcount} < Y_HI);
    assign w_h_frozen = (r_col == CELLS_C) && (r_h_off == LINE_LAST);
    assign w_v_frozen = (r_row == CELLS_C) && (r_v_off == LINE_LAST);

    // Stage 1: running offsets inside the current cell stand in for subtract-and-divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_off   <= '0;
            r_v_off   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_in_grid <= 1'b0;
            r_hc1     <= '0;
            r_vc1     <= '0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_hb1     <= 1'b0;
            r_vb1     <= 1'b0;
            r_rgb1    <= '0;
        end else begin
            if (in.hcount == X_START) begin
                r_h_off <= '0;
                r_col   <= '0;
            end else if (!w_h_frozen) begin
                if (r_h_off == OFF_LAST) begin
                    r_h_off <= '0;
                    r_col   <= r_col + 1'b1;
                end else begin
                    r_h_off <= r_h_off + 1'b1;
                end
            end
            if (in.hcount == '0) begin
                if (in.vcount == Y_START) begin
                    r_v_off <= '0;
                    r_row   <= '0;
                end else if (!w_v_frozen) begin
                    if (r_v_off == OFF_LAST) begin
                        r_v_off <= '0;
                        r_row   <= r_row + 1'b1;
                    end else begin
                        r_v_off <= r_v_off + 1'b1;
                    end
                end
            end
            r_in_grid <= w_in_grid;
            r_hc1     <= in.hcount;
            r_vc1     <= in.vcount;
            r_hs1     <= in.hsync;
            r_vs1     <= in.vsync;
            r_hb1     <= in.hblnk;
            r_vb1     <= in.vblnk;
            r_rgb1    <= in.rgb;
        end
    end

`ifdef HOVER_BLINK_EN
    logic [7:0] r_frame_cnt;
    logic       r_vblnk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt  <= '0;
            r_vblnk_prev <= 1'b1;
        end else begin
            r_vblnk_prev <= in.vblnk;
            if (in.vblnk && !r_vblnk_prev) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign w_blink_on = ~r_frame_cnt[BLINK_BIT];
`else
    assign w_blink_on = 1'b1;
`endif

    assign w_is_line   = (r_h_off < LINE_W_C) || (r_v_off < LINE_W_C);
    assign w_hover_hit = r_in_grid && hover_valid && w_blink_on &&
                         (r_col == hover_col) && (r_row == hover_row);

    always_comb begin
        w_rgb = r_rgb1;
        if (r_hb1 || r_vb1)            w_rgb = '0;
        else if (r_in_grid && w_is_line) w_rgb = LINE_RGB;
        else if (w_hover_hit)          w_rgb = HOVER_RGB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= r_hc1;
            out.vcount <= r_vc1;
            out.hsync  <= r_hs1;
            out.vsync  <= r_vs1;
            out.hblnk  <= r_hb1;
            out.vblnk  <= r_vb1;
            out.rgb    <= w_rgb;
        end
    end
endmodule

// File: tb/tb_draw_grid_ctl.sv
// tb/tb_draw_grid_ctl.sv - scoreboard bench for draw_grid_ctl on a shortened VGA frame
`timescale 1ns/1ps
module tb_draw_grid_ctl;
    import vga_pkg::*;

    localparam int XP = 100, YP = 50, NC = 10, PITCH = 32, LW = 2;
    localparam int V_ACTIVE = 400, V_TOTAL = 410, VB_LEN = 20;
    localparam int H_FIRST = 100, H_LAST = 439, H_BLANK = 430;

    typedef struct {
        int          due;
        bit          rst_chk;
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
    } pix_t;

    typedef struct {
        int          due;
        logic        valid;
        logic [3:0]  col;
        logic [3:0]  row;
    } hov_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] cursor_x = '0;
    logic [10:0] cursor_y = '0;
    grid_idx_t   hover_col;
    grid_idx_t   hover_row;
    logic        hover_valid;

    vga_if vin ();
    vga_if vout ();

    draw_grid_ctl #(.X_POS(XP), .Y_POS(YP)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (vin),
        .out         (vout),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .hover_col   (hover_col),
        .hover_row   (hover_row),
        .hover_valid (hover_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pix_t pix_q[$];
    hov_t hov_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_valid = 1'b0;
    int   m_col = 0, m_row = 0;

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rgb);
        int dx;
        int dy;
        dx = h - XP;
        dy = v - YP;
        if (hb || vb) return 12'h000;
        if (dx >= 0 && dx < NC * PITCH + LW && dy >= 0 && dy < NC * PITCH + LW) begin
            if ((dx % PITCH) < LW || (dy % PITCH) < LW) return 12'hfff;
            if (m_valid && (dx / PITCH) == m_col && (dy / PITCH) == m_row) return 12'h0a0;
        end
        return rgb;
    endfunction

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic r, input logic [11:0] rgb, input bit chk);
        pix_t e;
        @(posedge clk);
        #1;
        rst        = r;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hb;
        vin.vsync  = vb;
        vin.rgb    = rgb;
        if (chk) begin
            e.due     = cyc + 2;
            e.rst_chk = r;
            e.h       = 11'(h);
            e.v       = 11'(v);
            e.hb      = hb;
            e.vb      = vb;
            e.rgb     = r ? 12'h000 : exp_rgb(h, v, hb, vb, rgb);
            pix_q.push_back(e);
        end
    endtask

    task automatic push_hov(input int due, input logic valid, input int col, input int row);
        hov_t e;
        e.due   = due;
        e.valid = valid;
        e.col   = 4'(col);
        e.row   = 4'(row);
        hov_q.push_back(e);
    endtask

    // One frame; ev/ec/er are the hand-computed hover result of this frame's vblank.
    task automatic run_frame(input int cx, input int cy, input bit mv, input int mx, input int my,
                             input bit do_rst, input logic ev, input int ec, input int er);
        cursor_x = 11'(cx);
        cursor_y = 11'(cy);
        for (int v = 0; v < V_ACTIVE; v++) begin
            if (mv && v == 60) begin
                cursor_x = 11'(mx);
                cursor_y = 11'(my);
                push_hov(cyc + 2, m_valid, m_col, m_row);
            end
            if (v == 50 || v == 52 || v == 90 || v == 371) begin
                drive(0, v, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1);
                for (int h = H_FIRST; h <= H_LAST; h++)
                    drive(h, v, (h >= H_BLANK), 1'b0, 1'b0, 12'h123, 1'b1);
            end else begin
                drive(0, v, 1'b1, 1'b0, 1'b0, 12'h123, 1'b0);
            end
        end
        for (int v = V_ACTIVE; v < V_TOTAL; v++) begin
            for (int h = 0; h < VB_LEN; h++) begin
                drive(h, v, 1'b1, 1'b1, (do_rst && v == V_ACTIVE && h == 2), 12'h123, !do_rst);
                if (v == V_ACTIVE && h == 0) push_hov(cyc + NC + 4, ev, ec, er);
            end
        end
        m_valid = ev;
        m_col   = ec;
        m_row   = er;
    endtask

    pix_t pe;
    hov_t he;
    always @(negedge clk) begin
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pe = pix_q.pop_front();
            n_tests++;
            if (pe.due != cyc) begin
                n_fail++;
                $display("FAIL pix_late h=%0d v=%0d: checked at cycle %0d, required %0d", pe.h, pe.v, cyc, pe.due);
            end else if (pe.rst_chk) begin
                if (vout.rgb !== 12'h000 || vout.hcount !== 11'd0 || vout.vcount !== 11'd0 ||
                    vout.hsync !== 1'b0 || vout.vsync !== 1'b0 || vout.hblnk !== 1'b0 ||
                    vout.vblnk !== 1'b0 || hover_valid !== 1'b0 || hover_col !== 4'd0 ||
                    hover_row !== 4'd0) begin
                    n_fail++;
                    $display("FAIL reset_state: got rgb=%h hc=%0d vc=%0d sync=%b%b blk=%b%b hover=%b/%0d/%0d, want all zero",
                             vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                             vout.hblnk, vout.vblnk, hover_valid, hover_col, hover_row);
                end
            end else if (vout.rgb !== pe.rgb || vout.hcount !== pe.h || vout.vcount !== pe.v ||
                         vout.hblnk !== pe.hb || vout.vblnk !== pe.vb ||
                         vout.hsync !== pe.hb || vout.vsync !== pe.vb) begin
                n_fail++;
                $display("FAIL pixel h=%0d v=%0d: got rgb=%h hc=%0d vc=%0d blk=%b%b sync=%b%b, want rgb=%h blk=%b%b",
                         pe.h, pe.v, vout.rgb, vout.hcount, vout.vcount, vout.hblnk, vout.vblnk,
                         vout.hsync, vout.vsync, pe.rgb, pe.hb, pe.vb);
            end
        end
        while (hov_q.size() > 0 && hov_q[0].due <= cyc) begin
            he = hov_q.pop_front();
            n_tests++;
            if (he.due != cyc || hover_valid !== he.valid || hover_col !== he.col || hover_row !== he.row) begin
                n_fail++;
                $display("FAIL hover at cycle %0d: got valid=%b col=%0d row=%0d, want valid=%b col=%0d row=%0d",
                         cyc, hover_valid, hover_col, hover_row, he.valid, he.col, he.row);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: no finish after 5 ms of simulated time");
        $fatal(1, "watchdog");
    end

    initial begin
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = '0;
        for (int i = 0; i < 4; i++) drive(123 + i, 45, 1'b1, 1'b0, 1'b1, 12'hfff, 1'b1);

        run_frame(170, 90,  0, 0,   0,  0, 1'b1, 2, 1);
        run_frame(170, 90,  1, 250, 90, 0, 1'b1, 4, 1);
        run_frame(90,  90,  0, 0,   0,  0, 1'b0, 0, 0);
        run_frame(430, 60,  0, 0,   0,  0, 1'b0, 0, 0);
        run_frame(132, 82,  0, 0,   0,  0, 1'b1, 1, 1);
        run_frame(420, 60,  0, 0,   0,  0, 1'b0, 0, 0);
        run_frame(419, 369, 0, 0,   0,  0, 1'b1, 9, 9);
        run_frame(419, 369, 0, 0,   0,  1, 1'b0, 0, 0);
        run_frame(100, 50,  0, 0,   0,  0, 1'b1, 0, 0);
        run_frame(100, 50,  0, 0,   0,  0, 1'b1, 0, 0);

        for (int i = 0; i < 6; i++) drive(0, 0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        n_tests++;
        if (pix_q.size() != 0 || hov_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pixel and %0d hover entries left unchecked, want 0",
                     pix_q.size(), hov_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
